lcd_dfa_64_to_16: RTL and testbench
===================================

LCD_DFA_64_TO_16 -- requirements
Module: lcd_dfa_64_to_16

Interface
REQ-001 Parameters SHALL be: SYMBOL_WIDTH, 8, bits per symbol; IN_SYMBOLS, 8, symbols per input beat; OUT_SYMBOLS, 2, symbols per output beat.
REQ-002 Ports SHALL be, in order: clk  in  1  single clock, all logic rising-edge; reset_n  in  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  in  1  upstream FIFO has a beat; in_ready  out  1  adapter accepts beat this cycle.
REQ-004 in_data  in  69  [63:0] symbols, first symbol in [63:56]; [64] sop; [65] eop; [68:66] empty (invalid trailing bytes, meaningful only with eop).
REQ-005 out_ready  in  1  sink accepts; out_valid  out  1  output beat present.
REQ-006 out_data  out  16  two symbols, first symbol in [15:8]; out_sop  out  1; out_eop  out  1; out_empty  out  1  trailing invalid byte on last beat.
REQ-007 err_sop  out  1  one-cycle pulse on protocol error (REQ-019).

Function
REQ-008 Transfer SHALL occur on a rising edge where valid and ready are both high, on either side.
REQ-009 Each accepted input beat SHALL be held in one 69-bit holding register with a 2-bit sub-beat index idx and a 2-bit last index lst.
REQ-010 lst SHALL be 3 when eop=0; when eop=1, lst = (7 - empty) >> 1 (empty 0/1 -> 3, 2/3 -> 2, 4/5 -> 1, 6/7 -> 0).
REQ-011 out_data SHALL be holding symbols [63-16*idx -: 16]; out_valid SHALL equal the holding-valid flag.
REQ-012 out_sop SHALL be high only when idx=0 and held sop=1; out_eop only when idx=lst and held eop=1.
REQ-013 out_empty SHALL equal empty[0] when out_eop=1, else 0.
REQ-014 On each output transfer: if idx<lst, idx increments; if idx=lst, the held beat retires.
REQ-015 in_ready SHALL be high when holding is empty, or when out_ready=1 and idx=lst (retiring this cycle); a new beat then loads with idx=0 on the same edge, with no bubble cycle.
REQ-016 Latency: beat accepted at edge N SHALL present first output beat after edge N, valid during cycle N+1.
REQ-017 Throughput: with out_ready held high, an input beat with lst=k SHALL occupy exactly k+1 output cycles.
REQ-018 With out_ready low, all outputs SHALL hold stable while out_valid=1.
REQ-019 A state bit in_pkt SHALL set on output sop transfer and clear on output eop transfer; err_sop SHALL pulse the cycle after a sop is output while in_pkt=1, or a non-sop first beat is output while in_pkt=0; data SHALL still pass unchanged.
REQ-020 A beat with sop=1 and eop=1 SHALL be legal (single-beat packet).
REQ-021 Empty bits with eop=0 SHALL be ignored.

Reset
REQ-022 On reset_n low (async): holding-valid=0, idx=0, lst=0, in_pkt=0, out_valid=0, out_sop=0, out_eop=0, out_empty=0, err_sop=0, in_ready=1 when reset_n rises; out_data SHALL be 0.
REQ-023 Reset mid-packet SHALL discard the held beat; the first post-reset beat SHALL be treated as a fresh packet start (in_pkt=0).

Structure
REQ-024 The in_data field offsets (sop=64, eop=65, empty=68:66), 69-bit width, and the lst computation SHALL live in the shared lcd stream package, used also by the upstream FIFO wrapper.
REQ-025 No sub-module; one holding register plus control, 120-250 lines.

Verification
REQ-026 Single beat 0x0011223344556677, sop=1, eop=1, empty=0, out_ready=1 -> outputs 0x0011 (sop), 0x2233, 0x4455, 0x6677 (eop, empty=0) on consecutive cycles, err_sop=0.
REQ-027 Same beat with empty=3 -> outputs 0x0011 (sop), 0x2233, 0x4455 (eop, out_empty=1); in_ready high in the 0x4455 cycle.
REQ-028 Empty=7, sop=eop=1 -> one output 0x00xx with sop=eop=1, out_empty=1.
REQ-029 Three back-to-back beats (sop, mid, eop empty=0), out_ready=1 -> 12 consecutive out_valid cycles, no bubble, in_ready high only on each 4th.
REQ-030 Random out_ready stalls (50%) over 200 packets -> byte stream and sop/eop/empty match reference model; outputs stable during stalls.
REQ-031 Two sop beats without eop -> err_sop pulses once; reset_n asserted mid-packet -> out_valid=0 immediately, next packet output clean, err_sop=0.

Source files
------------

// File: rtl/lcd_dfa_64_to_16_pkg.sv
// Shared lcd stream definitions: the 69-bit beat layout and the last-sub-beat rule.
// Used by the 64->16 adapter and the upstream FIFO wrapper.
package lcd_dfa_64_to_16_pkg;

  // Packed so that data=[63:0], sop=[64], eop=[65], empty=[68:66].
  typedef struct packed {
    logic [2:0]  empty;
    logic        eop;
    logic        sop;
    logic [63:0] data;
  } lcd_beat_t;

  localparam int LCD_BEAT_W = $bits(lcd_beat_t);
  localparam int LCD_DATA_W = 64;

  // Index of the last 16-bit sub-beat that still carries a valid byte.
  function automatic logic [1:0] lcd_last_idx(input logic eop, input logic [2:0] empty);
    logic [2:0] valid_m1;
    valid_m1 = 3'd7 - empty;
    return eop ? valid_m1[2:1] : 2'd3;
  endfunction

endpackage

// File: rtl/lcd_dfa_64_to_16.sv
// Width adapter: one 64-bit lcd beat in, up to four 16-bit beats out, with
// packet framing carried through and a sop-protocol error pulse.
module lcd_dfa_64_to_16
  import lcd_dfa_64_to_16_pkg::*;
#(
  parameter int SYMBOL_WIDTH = 8,
  parameter int IN_SYMBOLS   = 8,
  parameter int OUT_SYMBOLS  = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LCD_BEAT_W-1:0]               in_data,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [SYMBOL_WIDTH*OUT_SYMBOLS-1:0] out_data,
  output logic                                out_sop,
  output logic                                out_eop,
  output logic                                out_empty,
  output logic                                err_sop
);

  localparam int OUT_W     = SYMBOL_WIDTH * OUT_SYMBOLS;
  localparam int SUB_BEATS = IN_SYMBOLS / OUT_SYMBOLS;

  lcd_beat_t  in_beat;
  lcd_beat_t  hold_reg, hold_next;
  logic       hold_valid_reg, hold_valid_next;
  logic [1:0] idx_reg, idx_next;
  logic [1:0] lst_reg, lst_next;
  logic       in_pkt_reg, in_pkt_next;
  logic       err_reg, err_next;

  logic       at_last;
  logic       out_xfer;
  logic       in_xfer;
  logic [OUT_W-1:0] sub_beat [SUB_BEATS];

  assign in_beat = lcd_beat_t'(in_data);

  // First symbol sits in the top byte, so sub-beat 0 is the most significant slice.
  genvar gi;
  generate
    for (gi = 0; gi < SUB_BEATS; gi++) begin : g_slice
      assign sub_beat[gi] = hold_reg.data[LCD_DATA_W-1-OUT_W*gi -: OUT_W];
    end
  endgenerate

  assign at_last  = (idx_reg == lst_reg);
  assign out_xfer = hold_valid_reg && out_ready;
  // Accept while the retiring sub-beat leaves, so back-to-back beats have no bubble.
  assign in_ready = !hold_valid_reg || (out_ready && at_last);
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      idx_reg        <= 2'd0;
      lst_reg        <= 2'd0;
      in_pkt_reg     <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      idx_reg        <= idx_next;
      lst_reg        <= lst_next;
      in_pkt_reg     <= in_pkt_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    idx_next        = idx_reg;
    lst_next        = lst_reg;
    in_pkt_next     = in_pkt_reg;
    err_next        = 1'b0;

    if (out_xfer) begin
      if (at_last) hold_valid_next = 1'b0;
      else         idx_next        = idx_reg + 2'd1;

      // Only the first sub-beat of a held beat can open a packet.
      if (idx_reg == 2'd0)
        err_next = hold_reg.sop ? in_pkt_reg : !in_pkt_reg;

      if (out_eop)      in_pkt_next = 1'b0;
      else if (out_sop) in_pkt_next = 1'b1;
    end

    if (in_xfer) begin
      hold_next       = in_beat;
      hold_valid_next = 1'b1;
      idx_next        = 2'd0;
      lst_next        = lcd_last_idx(in_beat.eop, in_beat.empty);
    end
  end

  always_comb begin
    out_valid = hold_valid_reg;
    out_data  = sub_beat[idx_reg];
    out_sop   = hold_valid_reg && (idx_reg == 2'd0) && hold_reg.sop;
    out_eop   = hold_valid_reg && at_last && hold_reg.eop;
    out_empty = out_eop && hold_reg.empty[0];
    err_sop   = err_reg;
  end

endmodule

// File: tb/tb_lcd_dfa_64_to_16.sv
// Self-checking bench for lcd_dfa_64_to_16: directed framing cases plus a
// randomized stall run checked against a packet-level byte model.
module tb_lcd_dfa_64_to_16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [68:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_empty;
  logic        err_sop;

  always #5 clk = ~clk;

  lcd_dfa_64_to_16 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_empty (out_empty),
    .err_sop   (err_sop)
  );

  typedef struct {
    logic [15:0] d;
    logic        sop;
    logic        eop;
    logic        emp;
    logic        first;
  } exp_t;

  exp_t        exp_q[$];
  logic [68:0] beat_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  bit          in_pkt_m = 0;
  bit          err_exp = 0;
  bit          prev_stall = 0;
  logic [18:0] prev_out = '0;
  int          cyc = 0;
  int          seg_valid, seg_rdy, seg_err, seg_first, seg_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [68:0] mk_beat(input logic [63:0] d, input bit sop, input bit eop,
                                          input logic [2:0] emp);
    return {emp, eop, sop, d};
  endfunction

  // Model: valid bytes of the beat, paired into 16-bit words in arrival order.
  function automatic void expand(input logic [68:0] b);
    logic [63:0] d;
    bit          sop, eop;
    int          nbytes, nout;
    exp_t        e;
    d      = b[63:0];
    sop    = b[64];
    eop    = b[65];
    nbytes = eop ? 8 - int'(b[68:66]) : 8;
    nout   = (nbytes + 1) / 2;
    for (int k = 0; k < nout; k++) begin
      e.d     = d[63-16*k -: 16];
      e.sop   = sop && (k == 0);
      e.eop   = eop && (k == nout - 1);
      e.emp   = e.eop && (nbytes % 2 == 1);
      e.first = (k == 0);
      exp_q.push_back(e);
    end
  endfunction

  task automatic seg_clear();
    seg_valid = 0; seg_rdy = 0; seg_err = 0; seg_first = -1; seg_last = -1;
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, account transfers.
  task automatic step(input int rdy_pct, input int vld_pct);
    exp_t e;
    in_valid  = (beat_q.size() > 0) && ($urandom_range(99) < vld_pct);
    in_data   = in_valid ? beat_q[0] : '0;
    out_ready = ($urandom_range(99) < rdy_pct);
    #1;
    chk("err_sop", err_sop, err_exp);
    if (err_sop) seg_err++;
    err_exp = 0;
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (prev_stall) chk("stall_hold", {out_data, out_sop, out_eop, out_empty}, prev_out);
    if (out_valid && exp_q.size() > 0) begin
      chk("out_data", out_data, exp_q[0].d);
      chk("out_sop", out_sop, exp_q[0].sop);
      chk("out_eop", out_eop, exp_q[0].eop);
      chk("out_empty", out_empty, exp_q[0].emp);
    end
    if (out_valid) begin
      seg_valid++;
      if (seg_first < 0) seg_first = cyc;
      seg_last = cyc;
      if (in_ready) seg_rdy++;
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_data, out_sop, out_eop, out_empty};
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.first) err_exp = e.sop ? in_pkt_m : !in_pkt_m;
      if (e.eop)      in_pkt_m = 0;
      else if (e.sop) in_pkt_m = 1;
    end
    if (in_valid && in_ready) expand(beat_q.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int rdy_pct, input int vld_pct, input int max_cyc);
    int c = 0;
    while ((beat_q.size() > 0 || exp_q.size() > 0) && c < max_cyc) begin
      step(rdy_pct, vld_pct);
      c++;
    end
    chk("drain", beat_q.size() + exp_q.size(), 0);
    step(rdy_pct, vld_pct);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_empty", out_empty, 0);
    chk("rst_err_sop", err_sop, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    beat_q.delete();
    exp_q.delete();
    in_pkt_m   = 0;
    err_exp    = 0;
    prev_stall = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int nb;
    #2;
    do_reset();

    // Single full beat, single-beat packet.
    seg_clear();
    beat_q.push_back(mk_beat(64'h0011223344556677, 1, 1, 3'd0));
    run(100, 100, 50);
    chk("full_cycles", seg_valid, 4);
    chk("full_span", seg_last - seg_first + 1, 4);
    chk("full_err", seg_err, 0);

    // Five valid bytes: three words, last one padded.
    seg_clear();
    beat_q.push_back(mk_beat(64'h0011223344556677, 1, 1, 3'd3));
    run(100, 100, 50);
    chk("e3_cycles", seg_valid, 3);
    chk("e3_in_ready", seg_rdy, 1);

    // One valid byte.
    seg_clear();
    beat_q.push_back(mk_beat(64'h0011223344556677, 1, 1, 3'd7));
    run(100, 100, 50);
    chk("e7_cycles", seg_valid, 1);

    // Three back-to-back beats of one packet.
    seg_clear();
    beat_q.push_back(mk_beat({$urandom, $urandom}, 1, 0, 3'd5));
    beat_q.push_back(mk_beat({$urandom, $urandom}, 0, 0, 3'd2));
    beat_q.push_back(mk_beat({$urandom, $urandom}, 0, 1, 3'd0));
    run(100, 100, 100);
    chk("b2b_cycles", seg_valid, 12);
    chk("b2b_span", seg_last - seg_first + 1, 12);
    chk("b2b_in_ready", seg_rdy, 3);
    chk("b2b_err", seg_err, 0);

    // Two sop beats with no eop in between.
    seg_clear();
    beat_q.push_back(mk_beat(64'h1111111111111111, 1, 0, 3'd0));
    beat_q.push_back(mk_beat(64'h2222222222222222, 1, 0, 3'd0));
    run(100, 100, 100);
    chk("dup_sop_err", seg_err, 1);

    // Reset in the middle of a packet, then a clean packet.
    beat_q.push_back(mk_beat(64'h3333333333333333, 1, 0, 3'd0));
    step(100, 100);
    step(100, 100);
    do_reset();
    seg_clear();
    beat_q.push_back(mk_beat(64'h8899AABBCCDDEEFF, 1, 1, 3'd1));
    run(100, 100, 50);
    chk("post_rst_cycles", seg_valid, 4);
    chk("post_rst_err", seg_err, 0);

    // Random packets with random output stalls and input gaps.
    seg_clear();
    for (int p = 0; p < 200; p++) begin
      nb = int'($urandom_range(4, 1));
      for (int b = 0; b < nb; b++)
        beat_q.push_back(mk_beat({$urandom, $urandom}, b == 0, b == nb - 1,
                                 3'($urandom_range(7))));
    end
    run(50, 80, 40000);
    chk("rand_err", seg_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
